// File: rtl/silencer_interpolator.sv
// Per-transducer silencer interpolator: steps each stored 8.8 intensity/phase
// toward its target by at most the supplied update rate, one sample per cycle.
module silencer_interpolator #(
    parameter int unsigned DEPTH = 249
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DIN_VALID,
    input  logic [7:0]  INTENSITY,
    input  logic [7:0]  PHASE,
    input  logic [15:0] UPDATE_RATE_INTENSITY,
    input  logic [15:0] UPDATE_RATE_PHASE,
    output logic        READY,
    output logic [7:0]  INTENSITY_OUT,
    output logic [7:0]  PHASE_OUT,
    output logic        DOUT_VALID
);

    localparam int unsigned AW = (DEPTH > 4) ? $clog2(DEPTH) : 2;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [AW-1:0]   clr_cnt;
    logic [AW-1:0]   clr_cnt_nxt;
    logic            ready_nxt;
    logic            mem_clr;
    logic            accept;

    logic [AW-1:0]   idx;
    logic            s1_valid;
    logic [AW-1:0]   s1_idx;
    logic [7:0]      s1_ti;
    logic [7:0]      s1_tp;
    logic [15:0]     s1_ri;
    logic [15:0]     s1_rp;
    logic [DW-1:0]   s1_cur;

    logic [DW-1:0]   mem [DEPTH];
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;

    logic [15:0]     cur_i;
    logic [15:0]     cur_p;
    logic [15:0]     tgt_i;
    logic [15:0]     tgt_p;
    logic [16:0]     sum_i;
    logic [15:0]     dn_i;
    logic [15:0]     d_p;
    logic [15:0]     e_p;
    logic [15:0]     new_i;
    logic [15:0]     new_p;

    // Control state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            READY   <= 1'b0;
        end else begin
            state   <= next_state;
            clr_cnt <= clr_cnt_nxt;
            READY   <= ready_nxt;
        end
    end

    // CLEAR sweeps every entry to zero once, then hands over to RUN
    always_comb begin
        next_state  = state;
        clr_cnt_nxt = clr_cnt;
        mem_clr     = 1'b0;
        case (state)
            CLEAR: begin
                mem_clr = 1'b1;
                if (clr_cnt == LAST) begin
                    next_state  = RUN;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + AW'(1);
                end
            end
            RUN: begin
                next_state = RUN;
            end
            default: begin
                next_state = CLEAR;
            end
        endcase
        ready_nxt = (next_state == RUN);
    end

    assign accept = DIN_VALID && (state == RUN);

    // Stage 0: index counter and input capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx      <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                idx <= (idx == LAST) ? '0 : idx + AW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            s1_idx <= idx;
            s1_ti  <= INTENSITY;
            s1_tp  <= PHASE;
            s1_ri  <= UPDATE_RATE_INTENSITY;
            s1_rp  <= UPDATE_RATE_PHASE;
        end
    end

    assign wr_en   = mem_clr || s1_valid;
    assign wr_addr = mem_clr ? clr_cnt : s1_idx;
    assign wr_data = mem_clr ? '0 : {new_i, new_p};

    // Current-value memory; read of idx never collides with the pending write
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        s1_cur <= mem[idx];
    end

    assign cur_i = s1_cur[31:16];
    assign cur_p = s1_cur[15:0];
    assign tgt_i = {s1_ti, 8'h00};
    assign tgt_p = {s1_tp, 8'h00};

    // Stage 1: clamped intensity step and shortest-path phase step
    always_comb begin
        sum_i = 17'(cur_i) + 17'(s1_ri);
        dn_i  = cur_i - tgt_i;
        new_i = cur_i;
        if (cur_i < tgt_i) begin
            new_i = (sum_i >= 17'(tgt_i)) ? tgt_i : sum_i[15:0];
        end else if (cur_i > tgt_i) begin
            new_i = (s1_ri >= dn_i) ? tgt_i : cur_i - s1_ri;
        end

        d_p   = tgt_p - cur_p;
        e_p   = cur_p - tgt_p;
        new_p = cur_p;
        if (d_p != 16'h0000) begin
            if (d_p <= 16'h8000) begin
                new_p = (s1_rp >= d_p) ? tgt_p : cur_p + s1_rp;
            end else begin
                new_p = (s1_rp >= e_p) ? tgt_p : cur_p - s1_rp;
            end
        end
    end

    // Stage 2: registered outputs alongside write-back
    always_ff @(posedge CLK) begin
        if (RST) begin
            DOUT_VALID    <= 1'b0;
            INTENSITY_OUT <= '0;
            PHASE_OUT     <= '0;
        end else begin
            DOUT_VALID <= s1_valid;
            if (s1_valid) begin
                INTENSITY_OUT <= new_i[15:8];
                PHASE_OUT     <= new_p[15:8];
            end
        end
    end

endmodule
